muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit; sits downstream of the register file beside the ALU.
//  Consumes the two register-read operands (rs1/rs2 values) plus funct3.
//  Produces a 32-bit result and write-back request (rd, regWrite) for the register-file write port.
//  One radix-2 step per cycle; fixed latency; single operation in flight.
// PARAMETERS
//  XLEN   32  operand/result width; iteration count = XLEN
//  CNT_W  5   iteration counter width, $clog2(XLEN)
// PORTS
//  clock     in   1     clock, rising edge
//  reset     in   1     synchronous, active-high
//  start     in   1     request; accepted only when busy==0
//  funct3    in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  operandA  in   XLEN  rs1 value (multiplicand / dividend)
//  operandB  in   XLEN  rs2 value (multiplier / divisor)
//  rdIn      in   5     destination register index, captured at accept
//  busy      out  1     high from cycle after accept through DONE cycle
//  done      out  1     one-cycle pulse, result valid
//  result    out  XLEN  final value; held until next accept
//  rdOut     out  5     captured rdIn
//  regWrite  out  1     = done && rdOut!=0 (x0 never written)
// BEHAVIOUR
//  Reset (reset==1 at posedge): state=IDLE; busy=0, done=0, regWrite=0, result=0, rdOut=0; counter=0.
//   Reset wins over everything, incl. mid-operation: in-flight op discarded, no done pulse.
//  FSM: IDLE -> RUN on start&&!busy; RUN -> DONE when count==XLEN-1; DONE -> IDLE unconditionally.
//  Accept edge N: latch funct3, rdIn; convert operands to magnitudes per signedness
//   (MUL/MULH/DIV/REM: both signed; MULHSU: A signed, B unsigned; others unsigned);
//   record result sign (mul: sA^sB; quotient: sA^sB; remainder: sA).
//  RUN: edges N+1..N+XLEN, one shift-add (mul, 2*XLEN product reg) or restoring
//   shift-subtract (div, XLEN remainder + quotient) step per edge.
//  DONE: state entered at edge N+XLEN; during that cycle done=1, busy=1; result is applied sign-fix
//   and selection: MUL low XLEN bits; MULH* high XLEN bits; DIV* quotient; REM* remainder.
//   Total accept->done: XLEN cycles (32). Next start accepted in cycle after DONE (busy=0).
//  start while busy: ignored, no effect on in-flight op or latched fields.
//  Special cases (fixed latency still applies, result overridden at DONE):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend (original operandA).
//   DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  Arithmetic: 2's complement negation modulo 2^XLEN; product full 2*XLEN before select.
//  operandA/B/funct3/rdIn need only be valid in the accept cycle.
// STRUCTURE
//  Shared header riscv_defs.vh: funct3 encodings (F3_MUL..F3_REMU), XLEN default, FSM state codes.
//  Single module; no sub-module required (mul/div share counter and FSM; separate datapath regs).
// TESTING
//  MUL 7*252 -> result=1764 (0x6E4), done exactly 32 cycles after accept, regWrite=1 (rd=5).
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
//  DIV x/0 -> 0xFFFFFFFF, REMU 0x1234/0 -> 0x1234; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  start pulses while busy with other operands -> ignored, original result delivered; rd=0 -> regWrite=0.
//  reset asserted at RUN count 10 -> next cycle busy=0, done=0, result=0; no done pulse follows.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_a_signed(input funct3_e f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
           (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic op_b_signed(input funct3_e f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle, fixed XLEN-cycle latency.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [4:0]      rdIn,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut,
  output logic            regWrite
);

  state_e state, state_nxt;

  funct3_e            f3_in, op;
  logic [CNT_W-1:0]   cnt;
  logic [2*XLEN-1:0]  prod, prod_nxt, prod_fix;
  logic [XLEN-1:0]    mcand, divisor, rem, quo, orig_a;
  logic [XLEN-1:0]    rem_nxt, quo_nxt, q_fix, r_fix, final_res;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [XLEN:0]      mul_sum, div_shift, div_diff;
  logic               s_a, s_b, neg_q, neg_r, divzero, last;

  assign f3_in = funct3_e'(funct3);
  assign s_a   = op_a_signed(f3_in) & operandA[XLEN-1];
  assign s_b   = op_b_signed(f3_in) & operandB[XLEN-1];
  assign a_mag = s_a ? (~operandA + 1'b1) : operandA;
  assign b_mag = s_b ? (~operandB + 1'b1) : operandB;
  assign last  = (cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath step values; the final step's outputs feed the result register directly.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt  = {mul_sum, prod[XLEN-1:1]};
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, divisor};
    if (!div_diff[XLEN]) begin
      rem_nxt = div_diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = div_shift[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
    prod_fix = neg_q ? (~prod_nxt + 1'b1) : prod_nxt;
    q_fix    = neg_q ? (~quo_nxt + 1'b1)  : quo_nxt;
    r_fix    = neg_r ? (~rem_nxt + 1'b1)  : rem_nxt;
    final_res = '0;
    case (op)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = divzero ? '1     : q_fix;
      F3_REM, F3_REMU:              final_res = divzero ? orig_a : r_fix;
      default:                      final_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op      <= F3_MUL;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      orig_a  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divzero <= 1'b0;
      result  <= '0;
      rdOut   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op      <= f3_in;
          rdOut   <= rdIn;
          cnt     <= '0;
          prod    <= {{XLEN{1'b0}}, b_mag};
          mcand   <= a_mag;
          divisor <= b_mag;
          rem     <= '0;
          quo     <= a_mag;
          orig_a  <= operandA;
          neg_q   <= s_a ^ s_b;
          neg_r   <= s_a;
          divzero <= (operandB == '0);
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            prod <= prod_nxt;
          end
          if (last) result <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign regWrite = done && (rdOut != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [4:0]  rdIn = '0;
  logic        busy, done, regWrite;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .operandA(operandA), .operandB(operandB), .rdIn(rdIn),
    .busy(busy), .done(done), .result(result), .rdOut(rdOut), .regWrite(regWrite)
  );

  // Issue one op, return result/latency/regWrite sampled in the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int noise,
                        output logic [31:0] r, output int lat, output logic rw);
    int guard = 0;
    logic got = 1'b0;
    @(negedge clock);
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    funct3 = f; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    operandA = 32'hDEAD_BEEF; operandB = 32'h0BAD_F00D; funct3 = ~f; rdIn = ~rd;
    r = 'x; rw = 1'bx; lat = 0;
    while (lat < 100 && !got) begin
      if (noise != 0) start = 1'b1;
      @(posedge clock); #1;
      lat++;
      if (done) begin got = 1'b1; r = result; rw = regWrite; end
    end
    start = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL timeout f3=%0d: no done within %0d cycles", f, lat); end
  endtask

  task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] r; int lat; logic rw;
    run_op(f, a, b, 5'd1, 0, r, lat, rw);
    total++;
    if (r !== exp) begin bad++; $display("FAIL %s: got %h want %h", name, r, exp); end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, regWrite, result, rdOut} !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b rw=%b result=%h rd=%0d want all 0",
               busy, done, regWrite, result, rdOut);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; logic rw;
    run_op(3'b000, 32'd7, 32'd252, 5'd5, 0, r, lat, rw);
    total++; if (r !== 32'h6E4) begin bad++; $display("FAIL mul_result: got %h want 000006e4", r); end
    total++; if (lat !== 32) begin bad++; $display("FAIL mul_latency: got %0d want 32", lat); end
    total++; if (rw !== 1'b1) begin bad++; $display("FAIL mul_regwrite: got %b want 1", rw); end
    total++; if (rdOut !== 5'd5) begin bad++; $display("FAIL mul_rdout: got %0d want 5", rdOut); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_done: got %b want 1", busy); end
    @(posedge clock); #1;
    total++;
    if ({busy, done, regWrite} !== 3'b000 || result !== 32'h6E4) begin
      bad++;
      $display("FAIL after_done: busy=%b done=%b rw=%b result=%h want 0 0 0 000006e4",
               busy, done, regWrite, result);
    end
  endtask

  task automatic test_mulh();
    check_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check_op("mulh",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    check_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    check_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
  endtask

  task automatic test_div();
    check_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    check_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    check_op("divu",     3'b101, 32'd100, 32'd7, 32'd14);
    check_op("remu",     3'b111, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_special();
    check_op("div_by0",   3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check_op("divu_by0",  3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check_op("remu_by0",  3'b111, 32'h1234, 32'd0, 32'h1234);
    check_op("rem_by0",   3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    check_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    check_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r; int lat; logic rw;
    run_op(3'b101, 32'd100, 32'd7, 5'd3, 1, r, lat, rw);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL busy_ignore_result: got %h want 0000000e", r); end
    total++; if (lat !== 32) begin bad++; $display("FAIL busy_ignore_latency: got %0d want 32", lat); end
    total++; if (rdOut !== 5'd3) begin bad++; $display("FAIL busy_ignore_rd: got %0d want 3", rdOut); end
  endtask

  task automatic test_rd0();
    logic [31:0] r; int lat; logic rw;
    run_op(3'b000, 32'd3, 32'd4, 5'd0, 0, r, lat, rw);
    total++; if (rw !== 1'b0) begin bad++; $display("FAIL rd0_regwrite: got %b want 0", rw); end
    total++; if (r !== 32'd12) begin bad++; $display("FAIL rd0_result: got %h want 0000000c", r); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clock);
    while (busy) @(negedge clock);
    funct3 = 3'b000; operandA = 32'd9; operandB = 32'd9; rdIn = 5'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++;
    if ({busy, done, regWrite} !== 3'b000 || result !== 32'd0 || rdOut !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b rw=%b result=%h rd=%0d want all 0",
               busy, done, regWrite, result, rdOut);
    end
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", seen); end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_busy_ignore();
    test_rd0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
